div_prenorm: RTL and testbench

- Operand pre-normalizer that sits directly upstream of the Goldschmidt divider datapath.
- Accepts raw unsigned integer numerator/denominator over a valid/ready handshake.
- Left-shifts each operand independently until its MSB lands at bit WIDTH-3, giving Q2.(WIDTH-2) values in [0.5,1) with the top two bits clear.
- Emits the normalized pair plus the exponent correction the post-stage needs to rescale the quotient.

---
 rtl/div_prenorm_if.sv | 29 ++
 rtl/div_prenorm.sv | 146 ++++++++++++++
 tb/tb_div_prenorm.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/div_prenorm_if.sv
// rtl/div_prenorm_if.sv - operand/result handshake bundle for the divider pre-normalizer
interface div_prenorm_if #(
  parameter int WIDTH = 28,
  parameter int SW    = $clog2(WIDTH-2)
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-3:0]    num_in;
  logic [WIDTH-3:0]    den_in;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    numerator;
  logic [WIDTH-1:0]    denominator;
  logic signed [SW:0]  exp_adj;
  logic                div_zero;
  logic                num_zero;

  // Pre-normalizer side
  modport slave (
    input  in_valid, num_in, den_in, out_ready,
    output in_ready, out_valid, numerator, denominator, exp_adj, div_zero, num_zero
  );

  // Operand source / divider side
  modport master (
    output in_valid, num_in, den_in, out_ready,
    input  in_ready, out_valid, numerator, denominator, exp_adj, div_zero, num_zero
  );
endinterface

// File: rtl/div_prenorm.sv
// rtl/div_prenorm.sv - Goldschmidt operand pre-normalizer; DIV_PRENORM_FAST_EN selects one-step shifting
module div_prenorm #(
  parameter int WIDTH = 28,
  parameter int SW    = $clog2(WIDTH-2)
) (
  input  logic         clk,
  input  logic         reset,
  div_prenorm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [SW-1:0]    sn_q, sn_d;
  logic [SW-1:0]    sd_q, sd_d;
  logic             div_zero_q, div_zero_d;
  logic             num_zero_q, num_zero_d;

  // An operand is finished once its MSB sits at WIDTH-3, or it is zero and can never get there
  logic num_done;
  logic den_done;
  assign num_done = num_q[WIDTH-3] || (num_q == '0);
  assign den_done = den_q[WIDTH-3] || (den_q == '0);

`ifdef DIV_PRENORM_FAST_EN
  // Shifts needed to bring the MSB of a raw operand up to WIDTH-3; zero needs none
  function automatic logic [SW-1:0] lzc(input logic [WIDTH-3:0] v);
    logic [SW-1:0] c;
    logic          found;
    c     = '0;
    found = 1'b0;
    for (int i = WIDTH-3; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      c     = c + 1'b1;
      end
    end
    if (!found) c = '0;
    return c;
  endfunction

  logic [SW-1:0] lz_num;
  logic [SW-1:0] lz_den;
  assign lz_num = lzc(bus.num_in);
  assign lz_den = lzc(bus.den_in);
`endif

  // Next-state and datapath: load on accept, normalize, then hold the result until consumed
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    den_d      = den_q;
    sn_d       = sn_q;
    sd_d       = sd_q;
    div_zero_d = div_zero_q;
    num_zero_d = num_zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          div_zero_d = (bus.den_in == '0);
          num_zero_d = (bus.num_in == '0);
`ifdef DIV_PRENORM_FAST_EN
          if (bus.den_in == '0) begin
            // A zero divisor passes N through untouched with no correction
            num_d = {2'b00, bus.num_in};
            den_d = '0;
            sn_d  = '0;
            sd_d  = '0;
          end else begin
            num_d = {2'b00, bus.num_in} << lz_num;
            den_d = {2'b00, bus.den_in} << lz_den;
            sn_d  = lz_num;
            sd_d  = lz_den;
          end
          state_d = OUT;
`else
          num_d   = {2'b00, bus.num_in};
          den_d   = {2'b00, bus.den_in};
          sn_d    = '0;
          sd_d    = '0;
          state_d = (bus.den_in == '0) ? OUT : NORM;
`endif
        end
      end

      NORM: begin
        // Exit is judged on the registered operands, so the last shift is seen one cycle later
        if (num_done && den_done) begin
          state_d = OUT;
        end else begin
          if (!num_done) begin
            num_d = num_q << 1;
            sn_d  = sn_q + 1'b1;
          end
          if (!den_done) begin
            den_d = den_q << 1;
            sd_d  = sd_q + 1'b1;
          end
        end
      end

      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and work registers; reset discards any pair in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      num_q      <= '0;
      den_q      <= '0;
      sn_q       <= '0;
      sd_q       <= '0;
      div_zero_q <= 1'b0;
      num_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      den_q      <= den_d;
      sn_q       <= sn_d;
      sd_q       <= sd_d;
      div_zero_q <= div_zero_d;
      num_zero_q <= num_zero_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == OUT);
  assign bus.numerator   = num_q;
  assign bus.denominator = den_q;
  assign bus.exp_adj     = $signed({1'b0, sd_q}) - $signed({1'b0, sn_q});
  assign bus.div_zero    = div_zero_q;
  assign bus.num_zero    = num_zero_q;

endmodule

// File: tb/tb_div_prenorm.sv
// tb/tb_div_prenorm.sv - scoreboard bench for div_prenorm
module tb_div_prenorm;
  localparam int WIDTH = 28;
  localparam int SW    = 5;
`ifdef DIV_PRENORM_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_prenorm_if #(.WIDTH(WIDTH), .SW(SW)) bus ();
  div_prenorm #(.WIDTH(WIDTH), .SW(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    int               ex;
    logic             dz;
    logic             nz;
    int               lat;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int lat_of(input int l);
    return FAST ? -1 : l;
  endfunction

  // Monitor: latency measured from accept edge to the edge that raises out_valid
  logic prev_v = 1'b0;
  int   first_cyc = 0;
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (bus.out_valid && !prev_v) first_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got numerator 0x%0h, expected no output", bus.numerator);
        end else begin
          e = sb.pop_front();
          check("numerator", 32'(bus.numerator), 32'(e.num));
          check("denominator", 32'(bus.denominator), 32'(e.den));
          check("exp_adj", 32'(int'(bus.exp_adj)), 32'(e.ex));
          check("div_zero", 32'(bus.div_zero), 32'(e.dz));
          check("num_zero", 32'(bus.num_zero), 32'(e.nz));
          if (e.lat >= 0) check("latency", 32'(first_cyc - e.acc), 32'(e.lat));
        end
      end
      prev_v = bus.out_valid;
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] en, input logic [WIDTH-1:0] ed, input int ex,
                          input logic dz, input logic nz, input int lat);
    exp_t x;
    x.num = en; x.den = ed; x.ex = ex; x.dz = dz; x.nz = nz; x.lat = lat; x.acc = cyc;
    sb.push_back(x);
  endtask

  // Called just after a rising edge; returns just after the accept edge
  task automatic send(input logic [WIDTH-3:0] n, input logic [WIDTH-3:0] d,
                      input logic [WIDTH-1:0] en, input logic [WIDTH-1:0] ed, input int ex,
                      input logic dz, input logic nz, input int lat);
    int w;
    bus.in_valid = 1'b1;
    bus.num_in   = n;
    bus.den_in   = d;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1 within 200 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    push_exp(en, ed, ex, dz, nz, lat);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb.size() != 0 || !bus.in_ready) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.num_in    = '0;
    bus.den_in    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_numerator", 32'(bus.numerator), 32'd0);
    check("rst_denominator", 32'(bus.denominator), 32'd0);
    check("rst_exp_adj", 32'(int'(bus.exp_adj)), 32'd0);
    check("rst_flags", 32'({bus.div_zero, bus.num_zero}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors
    send(26'h0000001, 26'h0000003, 28'h2000000, 28'h3000000, -1, 1'b0, 1'b0, lat_of(26));
    send(26'h3FFFFFF, 26'h2000000, 28'h3FFFFFF, 28'h2000000, 0, 1'b0, 1'b0, lat_of(1));
    send(26'h0000005, 26'h0000000, 28'h0000005, 28'h0000000, 0, 1'b1, 1'b0, -1);
    send(26'h0000000, 26'h0000100, 28'h0000000, 28'h2000000, 17, 1'b0, 1'b1, lat_of(18));
    send(26'h0000000, 26'h0000000, 28'h0000000, 28'h0000000, 0, 1'b1, 1'b1, -1);
    send(26'h0001234, 26'h3FFFFFF, 28'h2468000, 28'h3FFFFFF, -13, 1'b0, 1'b0, lat_of(14));
    wait_idle();

    // Backpressure: result must hold while out_ready is low, and no new accept until after transfer
    bus.out_ready = 1'b0;
    send(26'h0000003, 26'h0000002, 28'h3000000, 28'h2000000, 0, 1'b0, 1'b0, lat_of(25));
    w = 0;
    while (!bus.out_valid && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("hold_reached_out", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b1;
    bus.num_in   = 26'h0000080;
    bus.den_in   = 26'h0000001;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_numerator", 32'(bus.numerator), 32'h3000000);
      check("hold_denominator", 32'(bus.denominator), 32'h2000000);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_xfer_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_xfer_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    push_exp(28'h2000000, 28'h2000000, 7, 1'b0, 1'b0, lat_of(26));
    bus.in_valid = 1'b0;
    check("pending_accepted", 32'(bus.in_ready), FAST ? 32'd0 : 32'd0);
    wait_idle();

    // Reset in the middle of normalization
    bus.in_valid = 1'b1;
    bus.num_in   = 26'h0000001;
    bus.den_in   = 26'h0000001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_numerator", 32'(bus.numerator), 32'd0);
    check("midrst_denominator", 32'(bus.denominator), 32'd0);
    check("midrst_exp_adj", 32'(int'(bus.exp_adj)), 32'd0);
    check("midrst_flags", 32'({bus.div_zero, bus.num_zero}), 32'd0);
    reset = 1'b0;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    send(26'h2AAAAAA, 26'h0000007, 28'h2AAAAAA, 28'h3800000, 23, 1'b0, 1'b0, lat_of(24));
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
